// File: rtl/ps2_code_tracker_pkg.sv
// Shared types and constants for the PS/2 scan-code display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int PS2_DISP_W = 16;
  typedef logic [PS2_DISP_W-1:0] ps2_disp_t;

  // Prefix bytes seen so far in the sequence being assembled.
  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_seq_state_t;

endpackage

// File: rtl/ps2_code_tracker_if.sv
// Byte stream from the PS/2 receiver in, registered display word out.
// Latency: n/a (wiring only).
// Backpressure: none; bytes are strobes that must be taken when offered.
// Ports: byte_valid/byte_data/byte_error strobe one received byte, clear wipes
// the display; display_data/display_error/code_valid/code_ext/code_break carry
// the assembled code to the seven-segment decoder.
interface ps2_code_tracker_if;
  import ps2_pkg::*;

  logic      byte_valid;
  logic [7:0] byte_data;
  logic      byte_error;
  logic      clear;
  ps2_disp_t display_data;
  logic      display_error;
  logic      code_valid;
  logic      code_ext;
  logic      code_break;

  // master: the receive side / system driving bytes and clear
  modport master (
    output byte_valid, byte_data, byte_error, clear,
    input  display_data, display_error, code_valid, code_ext, code_break
  );

  // slave: the code tracker
  modport slave (
    input  byte_valid, byte_data, byte_error, clear,
    output display_data, display_error, code_valid, code_ext, code_break
  );

endinterface

// File: rtl/ps2_timeout.sv
// Watchdog down-counter: expires TIMEOUT_CYCLES-1 enabled clocks after restart.
// Latency: expired is combinational from the count; count updates each clock.
// Backpressure: none.
// Ports: clk/rst; clr zeroes the count; restart reloads it; enable lets it
// run down; expired is high while enabled with the count at zero.
module ps2_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      // Saturate at zero so expiry holds until the owner reacts.
      cnt <= cnt - W'(1);
    end
  end

  assign expired = enable && !restart && (cnt == '0);

endmodule

// File: rtl/ps2_code_tracker.sv
// Assembles E0/F0-prefixed PS/2 scan codes into the 16-bit hex display word.
// Latency: 1 clock from the final byte_valid to display_data/code_valid.
// Backpressure: none; every byte strobe is consumed, clear drops a same-cycle byte.
// Ports: clk/rst (async, active-high); bus is the slave side of ps2_code_tracker_if.
module ps2_code_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           rst,
  ps2_code_tracker_if.slave bus
);

  ps2_seq_state_t state;
  ps2_disp_t      disp_q;
  logic           err_q, vld_q, ext_q, brk_q;
  logic           expired;
  logic           accept;
  logic           is_ext, is_brk;

  assign accept = bus.byte_valid && !bus.clear;
  assign is_ext = (bus.byte_data == PS2_PREFIX_EXT);
  assign is_brk = (bus.byte_data == PS2_PREFIX_BRK);

  // Every accepted byte restarts the watchdog; it only runs while a prefix
  // is pending, so it never fires from IDLE.
  ps2_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clear),
    .restart (accept),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      disp_q <= '0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.clear) begin
        state  <= IDLE;
        disp_q <= '0;
        err_q  <= 1'b0;
        ext_q  <= 1'b0;
        brk_q  <= 1'b0;
      end else if (bus.byte_valid) begin
        if (bus.byte_error) begin
          state <= IDLE;
          err_q <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (is_ext)      state <= EXT;
              else if (is_brk) state <= BRK;
              else begin
                disp_q <= {8'h00, bus.byte_data};
                ext_q  <= 1'b0;
                brk_q  <= 1'b0;
                err_q  <= 1'b0;
                vld_q  <= 1'b1;
              end
            end
            EXT: begin
              // A repeated E0 just stays here; the watchdog is already restarted.
              if (is_brk)      state <= EXT_BRK;
              else if (is_ext) state <= EXT;
              else begin
                disp_q <= {PS2_PREFIX_EXT, bus.byte_data};
                ext_q  <= 1'b1;
                brk_q  <= 1'b0;
                err_q  <= 1'b0;
                vld_q  <= 1'b1;
                state  <= IDLE;
              end
            end
            BRK: begin
              if (is_brk) state <= BRK;
              else if (is_ext) begin
                // E0 after F0 is out of order.
                err_q <= 1'b1;
                state <= IDLE;
              end else begin
                disp_q <= {PS2_PREFIX_BRK, bus.byte_data};
                ext_q  <= 1'b0;
                brk_q  <= 1'b1;
                err_q  <= 1'b0;
                vld_q  <= 1'b1;
                state  <= IDLE;
              end
            end
            default: begin // EXT_BRK
              if (is_ext || is_brk) begin
                err_q <= 1'b1;
                state <= IDLE;
              end else begin
                disp_q <= {PS2_PREFIX_BRK, bus.byte_data};
                ext_q  <= 1'b1;
                brk_q  <= 1'b1;
                err_q  <= 1'b0;
                vld_q  <= 1'b1;
                state  <= IDLE;
              end
            end
          endcase
        end
      end else if (expired) begin
        // Abandoned prefix: show "Err", keep the last good code.
        state <= IDLE;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.display_data  = disp_q;
  assign bus.display_error = err_q;
  assign bus.code_valid    = vld_q;
  assign bus.code_ext      = ext_q;
  assign bus.code_break    = brk_q;

endmodule

// File: tb/tb_ps2_code_tracker.sv
// Scoreboard bench for ps2_code_tracker with TIMEOUT_CYCLES=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_code_tracker;
  import ps2_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        ext;
    logic        brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  exp_t mon_e;

  ps2_code_tracker_if bus();

  ps2_code_tracker #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.byte_error = e;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.byte_error = 1'b0;
    bus.byte_data  = 8'hF0; // junk while not valid; must be ignored
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_code(input logic [15:0] d, input logic x, input logic b);
    exp_t e;
    e.data = d;
    e.ext  = x;
    e.brk  = b;
    q.push_back(e);
  endtask

  // Monitor: every code_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.code_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_code: got %h, want no code", bus.display_data);
      end else begin
        mon_e = q.pop_front();
        check("code_data", bus.display_data, mon_e.data);
        check("code_ext", 16'(bus.code_ext), 16'(mon_e.ext));
        check("code_brk", 16'(bus.code_break), 16'(mon_e.brk));
        check("code_err_clr", 16'(bus.display_error), 16'h0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_error = 1'b0;
    bus.clear      = 1'b0;
    #12;
    check("rst_data", bus.display_data, 16'h0000);
    check("rst_err", 16'(bus.display_error), 16'h0);
    check("rst_vld", 16'(bus.code_valid), 16'h0);
    check("rst_ext", 16'(bus.code_ext), 16'h0);
    check("rst_brk", 16'(bus.code_break), 16'h0);
    rst = 1'b0;
    idle(1);

    // Plain make code
    expect_code(16'h001C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);
    idle(1);
    check("plain_hold", bus.display_data, 16'h001C);

    // Extended break, back-to-back
    expect_code(16'hF075, 1'b1, 1'b1);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    idle(2);

    // Receive error mid-sequence keeps the last code
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b1);
    check("rxerr_err", 16'(bus.display_error), 16'h1);
    check("rxerr_data", bus.display_data, 16'hF075);
    check("rxerr_ext", 16'(bus.code_ext), 16'h1);
    expect_code(16'h0032, 1'b0, 1'b0);
    send(8'h32, 1'b0);
    check("rxerr_recover", 16'(bus.display_error), 16'h0);

    // Timeout: error lands exactly 8 clocks after E0 is accepted
    send(8'hE0, 1'b0);
    idle(7);
    check("tmo_before", 16'(bus.display_error), 16'h0);
    idle(1);
    check("tmo_fire", 16'(bus.display_error), 16'h1);
    check("tmo_data", bus.display_data, 16'h0032);

    // A byte on the expiry cycle completes normally
    send(8'hE0, 1'b0);
    idle(7);
    expect_code(16'hE03A, 1'b1, 1'b0);
    send(8'h3A, 1'b0);
    check("tmo_edge_err", 16'(bus.display_error), 16'h0);

    // Protocol error F0 E0, then E0 E0 12
    send(8'hF0, 1'b0);
    send(8'hE0, 1'b0);
    check("proto_err", 16'(bus.display_error), 16'h1);
    check("proto_data", bus.display_data, 16'hE03A);
    expect_code(16'hE012, 1'b1, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h12, 1'b0);
    check("ee12_err", 16'(bus.display_error), 16'h0);

    // Async reset mid-sequence
    send(8'hE0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_data", bus.display_data, 16'h0000);
    check("arst_ext", 16'(bus.code_ext), 16'h0);
    check("arst_err", 16'(bus.display_error), 16'h0);
    #3 rst = 1'b0;
    idle(1);
    expect_code(16'h0029, 1'b0, 1'b0);
    send(8'h29, 1'b0);
    idle(1);

    // Clear beats a concurrent byte
    send(8'hF0, 1'b0);
    send(8'hE0, 1'b0);
    check("pre_clear_err", 16'(bus.display_error), 16'h1);
    bus.clear      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h1C;
    @(posedge clk); #1;
    bus.clear      = 1'b0;
    bus.byte_valid = 1'b0;
    check("clear_data", bus.display_data, 16'h0000);
    check("clear_err", 16'(bus.display_error), 16'h0);
    check("clear_vld", 16'(bus.code_valid), 16'h0);
    idle(3);

    check("queue_drained", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
